// File: rtl/rng_pkg.sv
// rtl/rng_pkg.sv - shared encodings, LFSR constants and limit-to-mask helper for rng_arbiter
package rng_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAW  = 2'd1,
    ST_CHECK = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Feedback taps 31,28,20,13,9,8,1 as a bit mask over the 32-bit state.
  localparam logic [31:0] LFSR_TAPS  = 32'h9010_2302;
  localparam logic [31:0] RESET_SEED = 32'hACE1_2468;

  // Smallest 2^k-1 covering limit-1; a zero limit means the full range.
  function automatic logic [31:0] mask_for_limit(input logic [31:0] limit);
    logic [31:0] v;
    if (limit == 32'd0) begin
      v = '1;
    end else begin
      v = limit - 32'd1;
      v = v | (v >> 1);
      v = v | (v >> 2);
      v = v | (v >> 4);
      v = v | (v >> 8);
      v = v | (v >> 16);
    end
    return v;
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// rtl/lfsr_step.sv - 32-bit Fibonacci LFSR register with step enable and synchronous seed load
module lfsr_step
  import rng_pkg::*;
#(
  parameter logic [31:0] SEED  = RESET_SEED,
  parameter int          OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_load,
  input  logic [31:0]      i_load_val,
  output logic [OUT_W-1:0] o_low
);

  logic [31:0] r_state;
  logic        w_fb;

  assign w_fb = ^(r_state & LFSR_TAPS);

  // A load wins over a step; the arbiter never requests both at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SEED;
    end else if (i_load) begin
      r_state <= i_load_val;
    end else if (i_en) begin
      r_state <= {r_state[30:0], w_fb};
    end
  end

  assign o_low = r_state[OUT_W-1:0];

endmodule

// File: rtl/rng_arbiter.sv
// rtl/rng_arbiter.sv - round-robin shared LFSR with rejection-sampled bounded results per requester
module rng_arbiter
  import rng_pkg::*;
#(
  parameter int          NREQ         = 4,
  parameter int          OUT_W        = 16,
  parameter int          MAX_TRIES    = 4,
  parameter logic [31:0] DEFAULT_SEED = RESET_SEED
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*OUT_W-1:0] req_limit,
  output logic [NREQ-1:0]       done,
  output logic [OUT_W-1:0]      rsp_data,
  input  logic                  reseed_valid,
  input  logic [31:0]           reseed_data,
  output logic                  reseed_ready,
  output logic                  busy
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TRY_W = $clog2(MAX_TRIES + 1);

  state_e           r_state;
  state_e           w_next;
  logic [IDX_W-1:0] r_last_grant;
  logic [IDX_W-1:0] r_winner;
  logic [IDX_W-1:0] w_pick;
  logic             w_any;
  logic [OUT_W-1:0] r_limit;
  logic [OUT_W-1:0] r_mask;
  logic [OUT_W-1:0] r_rsp_data;
  logic [OUT_W-1:0] w_sel_limit;
  logic [OUT_W-1:0] w_lfsr_low;
  logic [OUT_W-1:0] w_cand;
  logic [TRY_W-1:0] r_tries;
  logic             w_accept;
  logic             w_retry;
  logic             w_grant;
  logic             w_load;
  logic [31:0]      w_load_val;

  // Iterating from the far end lets the nearest set bit after last_grant win.
  always_comb begin
    int j;
    j      = 0;
    w_pick = r_last_grant;
    w_any  = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      j = (int'(r_last_grant) + k) % NREQ;
      if (req_valid[j]) begin
        w_pick = IDX_W'(j);
        w_any  = 1'b1;
      end
    end
  end

  assign w_sel_limit = req_limit[int'(w_pick)*OUT_W +: OUT_W];
  assign w_grant     = (r_state == ST_IDLE) && !reseed_valid && w_any;
  assign w_load      = (r_state == ST_IDLE) && reseed_valid;
  assign w_load_val  = (reseed_data == 32'd0) ? DEFAULT_SEED : reseed_data;

  lfsr_step #(
    .SEED  (DEFAULT_SEED),
    .OUT_W (OUT_W)
  ) u_lfsr (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_en       (r_state == ST_DRAW),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_low      (w_lfsr_low)
  );

  assign w_cand   = w_lfsr_low & r_mask;
  assign w_accept = (r_limit == '0) || (w_cand < r_limit);
  assign w_retry  = r_tries < TRY_W'(MAX_TRIES);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_grant) w_next = ST_DRAW;
      ST_DRAW:  w_next = ST_CHECK;
      ST_CHECK: begin
        if (w_accept)     w_next = ST_RESP;
        else if (w_retry) w_next = ST_DRAW;
        else              w_next = ST_RESP;
      end
      ST_RESP:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= IDX_W'(NREQ - 1);
      r_winner     <= '0;
      r_limit      <= '0;
      r_mask       <= '0;
      r_tries      <= '0;
      r_rsp_data   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_winner <= w_pick;
            r_limit  <= w_sel_limit;
            r_mask   <= OUT_W'(mask_for_limit(32'(w_sel_limit)));
            r_tries  <= '0;
          end
        end
        ST_DRAW: r_tries <= r_tries + 1'b1;
        ST_CHECK: begin
          // Fallback subtraction stays in range because mask < 2*limit.
          if (w_accept)      r_rsp_data <= w_cand;
          else if (!w_retry) r_rsp_data <= w_cand - r_limit;
        end
        ST_RESP: r_last_grant <= r_winner;
        default: ;
      endcase
    end
  end

  always_comb begin
    done         = '0;
    busy         = (r_state != ST_IDLE);
    reseed_ready = (r_state == ST_IDLE);
    rsp_data     = r_rsp_data;
    if (r_state == ST_RESP) done[r_winner] = 1'b1;
  end

endmodule

// File: tb/tb_rng_arbiter.sv
// tb/tb_rng_arbiter.sv - directed self-checking bench for rng_arbiter
module tb_rng_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [63:0] req_limit;
  logic [3:0]  done;
  logic [15:0] rsp_data;
  logic        reseed_valid;
  logic [31:0] reseed_data;
  logic        reseed_ready;
  logic        busy;

  logic [3:0]  req_valid1;
  logic [63:0] req_limit1;
  logic [3:0]  done1;
  logic [15:0] rsp_data1;
  logic        reseed_valid1;
  logic [31:0] reseed_data1;
  logic        reseed_ready1;
  logic        busy1;

  int checks;
  int errors;

  rng_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_limit(req_limit),
    .done(done), .rsp_data(rsp_data), .reseed_valid(reseed_valid),
    .reseed_data(reseed_data), .reseed_ready(reseed_ready), .busy(busy)
  );

  rng_arbiter #(.MAX_TRIES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_limit(req_limit1),
    .done(done1), .rsp_data(rsp_data1), .reseed_valid(reseed_valid1),
    .reseed_data(reseed_data1), .reseed_ready(reseed_ready1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic reseed(input logic [31:0] seed);
    reseed_valid = 1'b1;
    reseed_data  = seed;
    @(posedge clk); #1;
    reseed_valid = 1'b0;
    reseed_data  = 32'd0;
  endtask

  // Drives one request on the main DUT and reports what came back; leaves the DUT in IDLE.
  task automatic run_req(input int idx, input logic [15:0] lim,
                         output int cycles, output logic [15:0] data, output logic [3:0] d);
    cycles = -1;
    d      = 4'b0;
    data   = 16'hxxxx;
    req_limit[idx*16 +: 16] = lim;
    req_valid[idx] = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (done != 4'b0) begin
        cycles = c;
        d      = done;
        data   = rsp_data;
        break;
      end
    end
    req_valid[idx] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    checks++; if (done !== 4'b0) begin errors++; $display("FAIL reset_done: got %b want 0000", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (reseed_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", reseed_ready); end
    checks++; if (rsp_data !== 16'h0) begin errors++; $display("FAIL reset_rsp: got %h want 0000", rsp_data); end
    checks++; if (dut.u_lfsr.r_state !== 32'hACE1_2468) begin errors++; $display("FAIL reset_lfsr: got %h want ace12468", dut.u_lfsr.r_state); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_sequence;
    int cyc; logic [15:0] data; logic [3:0] d;
    logic [15:0] exp_data [3];
    exp_data[0] = 16'h0002; exp_data[1] = 16'h0005; exp_data[2] = 16'h000A;
    reseed(32'd1);
    checks++; if (dut.u_lfsr.r_state !== 32'd1) begin errors++; $display("FAIL seq_seed: got %h want 00000001", dut.u_lfsr.r_state); end
    for (int i = 0; i < 3; i++) begin
      run_req(i, 16'd0, cyc, data, d);
      checks++; if (d !== 4'(1 << i)) begin errors++; $display("FAIL seq_done%0d: got %b want %b", i, d, 4'(1 << i)); end
      checks++; if (data !== exp_data[i]) begin errors++; $display("FAIL seq_data%0d: got %h want %h", i, data, exp_data[i]); end
      checks++; if (cyc != 3) begin errors++; $display("FAIL seq_latency%0d: got %0d want 3", i, cyc); end
    end
  endtask

  task automatic test_reject;
    int cyc; logic [15:0] data; logic [3:0] d;
    run_req(3, 16'd5, cyc, data, d);
    checks++; if (d !== 4'b1000) begin errors++; $display("FAIL rej_done: got %b want 1000", d); end
    checks++; if (data !== 16'h0002) begin errors++; $display("FAIL rej_data: got %h want 0002", data); end
    checks++; if (cyc != 5) begin errors++; $display("FAIL rej_latency: got %0d want 5", cyc); end
  endtask

  task automatic test_max_tries_one;
    int cyc;
    logic [3:0] d;
    logic [15:0] data;
    cyc = -1; d = 4'b0; data = 16'hxxxx;
    reseed_valid1 = 1'b1; reseed_data1 = 32'h0000_000A;
    @(posedge clk); #1;
    reseed_valid1 = 1'b0;
    req_limit1[48 +: 16] = 16'd5;
    req_valid1[3] = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (done1 != 4'b0) begin cyc = c; d = done1; data = rsp_data1; break; end
    end
    req_valid1[3] = 1'b0;
    @(posedge clk); #1;
    checks++; if (d !== 4'b1000) begin errors++; $display("FAIL mt1_done: got %b want 1000", d); end
    checks++; if (data !== 16'h0000) begin errors++; $display("FAIL mt1_data: got %h want 0000", data); end
    checks++; if (cyc != 3) begin errors++; $display("FAIL mt1_latency: got %0d want 3", cyc); end
  endtask

  task automatic test_round_robin;
    logic [3:0] d;
    logic [15:0] data;
    int order [5];
    order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0;
    rst_n = 1'b0;
    req_valid = 4'hF;
    req_limit = {4{16'd1}};
    @(negedge clk); rst_n = 1'b1;
    for (int n = 0; n < 5; n++) begin
      if (n == 4) req_valid[0] = 1'b1;
      d = 4'b0; data = 16'hxxxx;
      for (int c = 1; c <= 20; c++) begin
        @(posedge clk); #1;
        if (done != 4'b0) begin d = done; data = rsp_data; break; end
      end
      checks++; if (d !== 4'(1 << order[n])) begin errors++; $display("FAIL rr_done%0d: got %b want %b", n, d, 4'(1 << order[n])); end
      checks++; if (data !== 16'h0) begin errors++; $display("FAIL rr_data%0d: got %h want 0000", n, data); end
      req_valid[order[n]] = 1'b0;
      @(posedge clk); #1;
    end
    req_valid = 4'b0;
  endtask

  task automatic test_reseed;
    int cyc; logic [15:0] data; logic [3:0] d;
    checks++; if (reseed_ready !== 1'b1) begin errors++; $display("FAIL rs_ready_idle: got %b want 1", reseed_ready); end
    reseed(32'd0);
    checks++; if (dut.u_lfsr.r_state !== 32'hACE1_2468) begin errors++; $display("FAIL rs_zero: got %h want ace12468", dut.u_lfsr.r_state); end
    req_limit[15:0] = 16'd0;
    req_valid[0] = 1'b1;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    reseed_valid = 1'b1; reseed_data = 32'h0000_1234;
    checks++; if (reseed_ready !== 1'b0) begin errors++; $display("FAIL rs_ready_busy: got %b want 0", reseed_ready); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rs_busy: got %b want 1", busy); end
    cyc = -1; d = 4'b0; data = 16'hxxxx;
    for (int c = 2; c <= 40; c++) begin
      @(posedge clk); #1;
      if (done != 4'b0) begin cyc = c; d = done; data = rsp_data; break; end
    end
    reseed_valid = 1'b0; reseed_data = 32'd0;
    checks++; if (d !== 4'b0001) begin errors++; $display("FAIL rs_done: got %b want 0001", d); end
    checks++; if (data !== 16'h48D0) begin errors++; $display("FAIL rs_data: got %h want 48d0", data); end
    checks++; if (cyc != 3) begin errors++; $display("FAIL rs_latency: got %0d want 3", cyc); end
    checks++; if (dut.u_lfsr.r_state !== 32'h59C2_48D0) begin errors++; $display("FAIL rs_ignored: got %h want 59c248d0", dut.u_lfsr.r_state); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_in_draw;
    int cyc; logic [15:0] data; logic [3:0] d;
    run_req(1, 16'd0, cyc, data, d);
    req_limit = 64'd0;
    req_valid = 4'b0101;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rd_busy_before: got %b want 1", busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (done !== 4'b0) begin errors++; $display("FAIL rd_done: got %b want 0000", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rd_busy: got %b want 0", busy); end
    checks++; if (dut.u_lfsr.r_state !== 32'hACE1_2468) begin errors++; $display("FAIL rd_lfsr: got %h want ace12468", dut.u_lfsr.r_state); end
    @(negedge clk); rst_n = 1'b1;
    cyc = -1; d = 4'b0; data = 16'hxxxx;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (done != 4'b0) begin cyc = c; d = done; data = rsp_data; break; end
    end
    checks++; if (d !== 4'b0001) begin errors++; $display("FAIL rd_regrant: got %b want 0001", d); end
    checks++; if (data !== 16'h48D0) begin errors++; $display("FAIL rd_data: got %h want 48d0", data); end
    checks++; if (cyc != 3) begin errors++; $display("FAIL rd_latency: got %0d want 3", cyc); end
    req_valid[0] = 1'b0;
    d = 4'b0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (done != 4'b0) begin d = done; break; end
    end
    checks++; if (d !== 4'b0100) begin errors++; $display("FAIL rd_next: got %b want 0100", d); end
    req_valid = 4'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    req_valid     = 4'b0;
    req_limit     = 64'd0;
    reseed_valid  = 1'b0;
    reseed_data   = 32'd0;
    req_valid1    = 4'b0;
    req_limit1    = 64'd0;
    reseed_valid1 = 1'b0;
    reseed_data1  = 32'd0;
    @(posedge clk); #1;
    test_reset;
    test_sequence;
    test_reject;
    test_max_tries_one;
    test_round_robin;
    test_reseed;
    test_reset_in_draw;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rng_arbiter.md
Name: rng_arbiter

Overview:
- Shares one 32-bit Fibonacci LFSR random source between NREQ graphics requesters (sprite placement, colour jitter, spawn timers).
- Arbitrates requests round-robin and advances the LFSR only on demand, so sequences are reproducible from a seed.
- Returns an unbiased value in [0, limit) per request using masked rejection sampling with a bounded retry fallback.
- Accepts software/host reseeds between requests.

Parameters:
- NREQ, 4: number of requesters (2..8).
- OUT_W, 16: result and limit width.
- MAX_TRIES, 4: LFSR draws per request before fallback (>=1).
- DEFAULT_SEED, 32'hACE1_2468: reset seed; also replaces any all-zero reseed.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NREQ  per-requester request; held high until its done bit.
- req_limit  in  NREQ*OUT_W  flattened limits; slice i belongs to requester i. 0 means 2^OUT_W.
- done  out  NREQ  one-hot, one-cycle pulse: result for that requester is valid.
- rsp_data  out  OUT_W  result, valid only while done is nonzero.
- reseed_valid  in  1  load reseed_data into the LFSR.
- reseed_data  in  32  new seed.
- reseed_ready  out  1  high when the FSM is in IDLE.
- busy  out  1  high when the FSM is not in IDLE.

Behaviour:
- LFSR step: lfsr <= {lfsr[30:0], fb}, where fb = lfsr[31]^lfsr[28]^lfsr[20]^lfsr[13]^lfsr[9]^lfsr[8]^lfsr[1]. The LFSR advances only in DRAW. Candidate = lfsr[OUT_W-1:0] & mask, using the post-step value.
- Reset values: state=IDLE, lfsr=DEFAULT_SEED, done=0, rsp_data=0, busy=0, last_grant=NREQ-1, tries=0. Reset is honoured in every state. A reset mid-request discards the request; no done pulse is issued.
- IDLE:
  - reseed_valid has priority over requests. It loads reseed_data, or DEFAULT_SEED if reseed_data==0, and the FSM stays in IDLE that cycle.
  - Otherwise, if any req_valid is high, grant the first set bit searching from last_grant+1 with wrap-around. Latch winner, limit and mask, set tries=0, then go to DRAW.
  - reseed_valid outside IDLE is ignored. reseed_ready is low outside IDLE.
- mask: smallest 2^k-1 >= limit-1. limit=1 gives mask 0; limit=10 gives mask 15; limit=0 gives all ones.
- DRAW: step the LFSR, tries++, go to CHECK.
- CHECK:
  - If limit==0 or cand<limit, register rsp_data=cand and go to RESP.
  - Else if tries<MAX_TRIES, go to DRAW.
  - Else register rsp_data=cand-limit and go to RESP. This is always in range because mask<2*limit.
- RESP: done[winner]=1 for exactly this cycle, last_grant=winner, then go to IDLE. The requester must deassert req_valid at the edge ending RESP.
- Latency: first-draw acceptance gives done 3 cycles after the grant cycle (IDLE, DRAW, CHECK, RESP). Each rejection adds 2 cycles. Worst case is 1+2*MAX_TRIES+1 cycles.
- req_valid and req_limit are sampled only in IDLE. Changes while busy are ignored.
- No starvation: a continuously asserted requester is served within NREQ grants.

Decomposition:
- Shared package rng_pkg: state encoding (IDLE, DRAW, CHECK, RESP), LFSR tap constants, DEFAULT_SEED, and a mask_for_limit function.
- Sub-module lfsr_step: 32-bit register with enable, synchronous load and load value, and async reset to the seed parameter. It contains the only copy of the tap equation.
- The round-robin pick stays inline.

Test Plan:
- Default parameters unless a scenario states otherwise.
- Reset, reseed 1, then requests from req0, req1, req2 in turn, each with limit=0. Required: rsp_data 0x0002, 0x0005, 0x000A. Each done arrives exactly 3 cycles after its grant.
- Continue from the previous scenario with req3, limit=5 (mask 7). Required: step to 0x15 gives candidate 5, rejected; step to 0x2A gives 2, accepted. done[3] arrives 5 cycles after the grant with rsp_data=2.
- Same sequence with MAX_TRIES=1. Required: candidate 5 rejected, retries exhausted, rsp_data=0 (5-5). done arrives 3 cycles after the grant.
- All four req_valid held from reset, limit=1. Required: done order 0,1,2,3, then 0 again when req0 re-asserts; every rsp_data=0.
- reseed_data=0 in IDLE. Required: LFSR equals DEFAULT_SEED. reseed_valid while busy: ignored, reseed_ready=0.
- rst_n low during DRAW. Required: immediately done=0, busy=0, lfsr=DEFAULT_SEED. After release, a pending request is re-granted from requester 0.
